// File: rtl/pipelined_adder_if.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_adder_if
//  Description : Valid/ready operand and result bundle for pipelined_adder.
//                The slave side is the adder; the master side drives operands
//                and consumes results.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pipelined_adder_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             carry;
    logic             overflow;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, carry, overflow
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, carry, overflow
    );
endinterface
`default_nettype wire

// File: rtl/pipelined_adder.sv
`default_nettype none
// ============================================================================
//  Module      : pipelined_adder
//  Description : WIDTH-bit a + b + cin split into STAGES equal carry-ripple
//                chunks, one register stage per chunk, valid/ready handshake
//                with per-stage bubble collapsing. Produces unsigned carry and
//                two's-complement overflow alongside the sum.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    pipelined_adder_if.slave bus
);
    localparam int C_CHUNK = WIDTH / STAGES;

    // Per-stage state. Each stage carries the full operands so the next stage
    // can slice its own chunk; bits already consumed are pruned in synthesis.
    logic [STAGES-1:0] r_valid;
    logic [WIDTH-1:0]  r_a   [STAGES];
    logic [WIDTH-1:0]  r_b   [STAGES];
    logic [WIDTH-1:0]  r_sum [STAGES];
    logic [STAGES-1:0] r_cout;
    logic              r_ovf;

    logic [STAGES:0]   w_ready;
    logic [STAGES-1:0] w_vin;
    logic [WIDTH-1:0]  w_a_in    [STAGES];
    logic [WIDTH-1:0]  w_b_in    [STAGES];
    logic [WIDTH-1:0]  w_sum_nx  [STAGES];
    logic [STAGES-1:0] w_cout_nx;
    logic              w_ovf_nx;

    // Valid entering each stage: upstream stage valid, or in_valid for stage 0.
    assign w_vin = STAGES'({r_valid, bus.in_valid});

    // Chunk arithmetic for every stage
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * C_CHUNK;

        logic [C_CHUNK-1:0] w_s;
        logic               w_co;
        logic               w_ci;
        logic [WIDTH-1:0]   w_low;

        if (k == 0) begin : g_first
            assign w_a_in[k] = bus.a;
            assign w_b_in[k] = bus.b;
            assign w_ci      = bus.cin;
            assign w_low     = '0;
        end else begin : g_next
            assign w_a_in[k] = r_a[k-1];
            assign w_b_in[k] = r_b[k-1];
            assign w_ci      = r_cout[k-1];
            assign w_low     = r_sum[k-1];
        end

        assign {w_co, w_s}  = {1'b0, w_a_in[k][LO +: C_CHUNK]}
                            + {1'b0, w_b_in[k][LO +: C_CHUNK]}
                            + {{C_CHUNK{1'b0}}, w_ci};
        assign w_sum_nx[k]  = w_low | (WIDTH'(w_s) << LO);
        assign w_cout_nx[k] = w_co;

        // Carry into the MSB is recovered as sum ^ a ^ b at that bit, so
        // overflow = carry_in(MSB) ^ carry_out(MSB).
        if (k == STAGES - 1) begin : g_last
            assign w_ovf_nx = w_co ^ w_s[C_CHUNK-1]
                            ^ w_a_in[k][WIDTH-1] ^ w_b_in[k][WIDTH-1];
        end
    end

    // Ready ripples back from out_ready; an empty stage is always ready.
    always_comb begin
        w_ready         = '0;
        w_ready[STAGES] = bus.out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_ready[k] = !r_valid[k] || w_ready[k+1];
        end
    end

    // Pipeline registers: a stage loads whenever it is ready, otherwise holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
            r_cout  <= '0;
            r_ovf   <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                r_a[k]   <= '0;
                r_b[k]   <= '0;
                r_sum[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_ready[k]) begin
                    r_valid[k] <= w_vin[k];
                    r_a[k]     <= w_a_in[k];
                    r_b[k]     <= w_b_in[k];
                    r_sum[k]   <= w_sum_nx[k];
                    r_cout[k]  <= w_cout_nx[k];
                end
            end
            if (w_ready[STAGES-1]) begin
                r_ovf <= w_ovf_nx;
            end
        end
    end

    assign bus.in_ready  = w_ready[0];
    assign bus.out_valid = r_valid[STAGES-1];
    assign bus.sum       = r_sum[STAGES-1];
    assign bus.carry     = r_cout[STAGES-1];
    assign bus.overflow  = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipelined_adder
//  Description : Directed bench for pipelined_adder: an 8-bit/2-stage instance
//                for arithmetic corner cases and a 32-bit/4-stage instance for
//                streaming, backpressure and reset behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipelined_adder;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        v;
        int          t;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    // Count rising edges so latency can be measured in cycles
    always @(posedge clk) cyc <= cyc + 1;

    pipelined_adder_if #(.WIDTH(8))  i8  ();
    pipelined_adder_if #(.WIDTH(32)) i32 ();

    pipelined_adder #(.WIDTH(8), .STAGES(2)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (i8.slave)
    );

    pipelined_adder #(.WIDTH(32), .STAGES(4)) dut32 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (i32.slave)
    );

    function automatic exp_t model32(input logic [31:0] a, input logic [31:0] b,
                                     input logic ci, input int t);
        exp_t        e;
        logic [32:0] r;
        r   = {1'b0, a} + {1'b0, b} + {32'b0, ci};
        e.s = r[31:0];
        e.c = r[32];
        e.v = (a[31] == b[31]) && (r[31] != a[31]);
        e.t = t;
        return e;
    endfunction

    task automatic test_reset();
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({i8.out_valid, i8.carry, i8.overflow, i8.sum} !== 11'h000) begin
            bad++;
            $display("FAIL reset_out8 got=%h exp=000", {i8.out_valid, i8.carry, i8.overflow, i8.sum});
        end
        total++;
        if ({i32.out_valid, i32.carry, i32.overflow, i32.sum} !== 35'h0) begin
            bad++;
            $display("FAIL reset_out32 got=%h exp=0", {i32.out_valid, i32.carry, i32.overflow, i32.sum});
        end
        rst_n = 1'b1;
        #1;
        total++;
        if ({i8.in_ready, i32.in_ready} !== 2'b11) begin
            bad++;
            $display("FAIL reset_in_ready got=%b exp=11", {i8.in_ready, i32.in_ready});
        end
    endtask

    task automatic test_fa_truth();
        logic [2:0] v;
        logic [7:0] es;
        i8.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            v  = i[2:0];
            es = 8'(v[2]) + 8'(v[1]) + 8'(v[0]);
            @(negedge clk);
            i8.a        = {7'b0, v[2]};
            i8.b        = {7'b0, v[1]};
            i8.cin      = v[0];
            i8.in_valid = 1'b1;
            #1;
            total++;
            if (i8.in_ready !== 1'b1) begin
                bad++;
                $display("FAIL fa_in_ready[%0d] got=%b exp=1", i, i8.in_ready);
            end
            @(negedge clk);
            i8.in_valid = 1'b0;
            total++;
            if (i8.out_valid !== 1'b0) begin
                bad++;
                $display("FAIL fa_early[%0d] out_valid got=%b exp=0", i, i8.out_valid);
            end
            @(negedge clk);
            total++;
            if ({i8.out_valid, i8.carry, i8.overflow, i8.sum} !== {1'b1, 1'b0, 1'b0, es}) begin
                bad++;
                $display("FAIL fa_result[%0d] got v=%b c=%b o=%b s=%h exp v=1 c=0 o=0 s=%h",
                         i, i8.out_valid, i8.carry, i8.overflow, i8.sum, es);
            end
        end
    endtask

    task automatic test_boundary8();
        logic [7:0] ta [4] = '{8'hFF, 8'h7F, 8'h80, 8'h0F};
        logic [7:0] tb [4] = '{8'h00, 8'h01, 8'h80, 8'h01};
        logic       tc [4] = '{1'b1,  1'b0,  1'b0,  1'b0};
        logic [7:0] ts [4] = '{8'h00, 8'h80, 8'h00, 8'h10};
        logic       tk [4] = '{1'b1,  1'b0,  1'b1,  1'b0};
        logic       to [4] = '{1'b0,  1'b1,  1'b1,  1'b0};
        i8.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            i8.a        = ta[i];
            i8.b        = tb[i];
            i8.cin      = tc[i];
            i8.in_valid = 1'b1;
            @(negedge clk);
            i8.in_valid = 1'b0;
            @(negedge clk);
            total++;
            if ({i8.out_valid, i8.carry, i8.overflow, i8.sum} !== {1'b1, tk[i], to[i], ts[i]}) begin
                bad++;
                $display("FAIL bound8[%0d] got v=%b c=%b o=%b s=%h exp v=1 c=%b o=%b s=%h",
                         i, i8.out_valid, i8.carry, i8.overflow, i8.sum, tk[i], to[i], ts[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int          n_sent = 0;
        int          n_got  = 0;
        int          guard  = 0;
        logic [31:0] a, b;
        logic        ci;
        exp_t        e;
        q.delete();
        i32.out_ready = 1'b1;
        while (n_got < 100 && guard < 300) begin
            @(negedge clk);
            guard++;
            if (i32.out_valid) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_spurious got s=%h exp no result", i32.sum);
                end else begin
                    e = q.pop_front();
                    n_got++;
                    if ({i32.carry, i32.overflow, i32.sum} !== {e.c, e.v, e.s} || cyc - e.t != 4) begin
                        bad++;
                        $display("FAIL b2b[%0d] got c=%b o=%b s=%h lat=%0d exp c=%b o=%b s=%h lat=4",
                                 n_got, i32.carry, i32.overflow, i32.sum, cyc - e.t, e.c, e.v, e.s);
                    end
                end
            end
            if (n_sent < 100) begin
                if (n_sent == 0) begin
                    a = 32'hFFFF_FFFF; b = 32'h0; ci = 1'b1;
                end else begin
                    a = $urandom; b = $urandom; ci = 1'($urandom_range(0, 1));
                end
                i32.a = a; i32.b = b; i32.cin = ci; i32.in_valid = 1'b1;
                #1;
                total++;
                if (i32.in_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_in_ready[%0d] got=%b exp=1", n_sent, i32.in_ready);
                end
                q.push_back(model32(a, b, ci, cyc));
                n_sent++;
            end else begin
                i32.in_valid = 1'b0;
            end
        end
        total++;
        if (n_got != 100) begin
            bad++;
            $display("FAIL b2b_count got=%0d exp=100", n_got);
        end
    endtask

    task automatic test_backpressure();
        int          n_acc = 0;
        int          n_ret = 0;
        logic        ordy, ivld;
        logic [31:0] a, b;
        logic        ci;
        q.delete();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (i < 6)       ordy = 1'b0;
            else if (i < 16) ordy = 1'b1;
            else if (i < 80) ordy = 1'($urandom_range(0, 1));
            else             ordy = 1'b1;
            if (i < 16)      ivld = 1'b1;
            else if (i < 80) ivld = 1'($urandom_range(0, 1));
            else             ivld = 1'b0;
            if (i32.out_valid) begin
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL bp_spurious[%0d] got s=%h exp no result", i, i32.sum);
                end else begin
                    if ({i32.carry, i32.overflow, i32.sum} !== {q[0].c, q[0].v, q[0].s}) begin
                        bad++;
                        $display("FAIL bp_data[%0d] got c=%b o=%b s=%h exp c=%b o=%b s=%h",
                                 i, i32.carry, i32.overflow, i32.sum, q[0].c, q[0].v, q[0].s);
                    end
                    if (ordy) begin
                        void'(q.pop_front());
                        n_ret++;
                    end
                end
            end
            if (i >= 80 && q.size() == 0) break;
            a = $urandom; b = $urandom; ci = 1'($urandom_range(0, 1));
            i32.out_ready = ordy;
            i32.in_valid  = ivld;
            i32.a = a; i32.b = b; i32.cin = ci;
            #1;
            if (i < 6) begin
                total++;
                if (i32.in_ready !== (i < 4)) begin
                    bad++;
                    $display("FAIL bp_fill_ready[%0d] got=%b exp=%b", i, i32.in_ready, (i < 4));
                end
            end else if (i < 16) begin
                total++;
                if (i32.in_ready !== 1'b1) begin
                    bad++;
                    $display("FAIL bp_release_ready[%0d] got=%b exp=1", i, i32.in_ready);
                end
            end
            if (ivld && i32.in_ready) begin
                q.push_back(model32(a, b, ci, cyc));
                n_acc++;
            end
            if (i == 5) begin
                total++;
                if (n_acc != 4) begin
                    bad++;
                    $display("FAIL bp_absorb got=%0d exp=4", n_acc);
                end
            end
        end
        i32.in_valid = 1'b0;
        total++;
        if (q.size() != 0 || n_ret != n_acc) begin
            bad++;
            $display("FAIL bp_drain got left=%0d ret=%0d exp left=0 ret=%0d", q.size(), n_ret, n_acc);
        end
        @(negedge clk);
        total++;
        if (i32.out_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_dup got out_valid=%b exp=0", i32.out_valid);
        end
    endtask

    task automatic test_reset_midflight();
        i32.out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            i32.a = 32'h8000_0001 + j; i32.b = 32'h8000_0001; i32.cin = 1'b0;
            i32.in_valid = 1'b1;
        end
        @(negedge clk);
        i32.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({i32.out_valid, i32.carry, i32.overflow, i32.sum} !== {1'b1, 1'b1, 1'b1, 32'h2}) begin
            bad++;
            $display("FAIL rst_pre got v=%b c=%b o=%b s=%h exp v=1 c=1 o=1 s=00000002",
                     i32.out_valid, i32.carry, i32.overflow, i32.sum);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({i32.out_valid, i32.carry, i32.overflow, i32.sum} !== 35'h0) begin
            bad++;
            $display("FAIL rst_async got v=%b c=%b o=%b s=%h exp all 0",
                     i32.out_valid, i32.carry, i32.overflow, i32.sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        i32.out_ready = 1'b1;
        #1;
        total++;
        if (i32.in_ready !== 1'b1) begin
            bad++;
            $display("FAIL rst_in_ready got=%b exp=1", i32.in_ready);
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            total++;
            if (i32.out_valid !== 1'b0) begin
                bad++;
                $display("FAIL rst_stale[%0d] got out_valid=%b s=%h exp 0", k, i32.out_valid, i32.sum);
            end
        end
    endtask

    initial begin
        i8.in_valid   = 1'b0; i8.a  = '0; i8.b  = '0; i8.cin  = 1'b0; i8.out_ready  = 1'b0;
        i32.in_valid  = 1'b0; i32.a = '0; i32.b = '0; i32.cin = 1'b0; i32.out_ready = 1'b0;
        test_reset();
        test_fa_truth();
        test_boundary8();
        test_back_to_back();
        test_backpressure();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined successor to the single-bit full adder: WIDTH-bit a + b + cin, split into STAGES equal carry-ripple chunks with a register after each chunk.
- Valid/ready handshake on input and output; per-stage bubble collapsing; full throughput (one add per clock) when unstalled.
- Shared arithmetic datapath primitive for wider units (accumulators, address generators) in this codebase.

Parameters:
- WIDTH, 32, operand/sum width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages (1..WIDTH); chunk width C = WIDTH/STAGES.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  a/b/cin valid this cycle
- in_ready  output  1  block accepts input this cycle
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry in
- out_valid  output  1  sum/carry/overflow valid
- out_ready  input  1  downstream accepts result
- sum  output  WIDTH  (a+b+cin) mod 2^WIDTH
- carry  output  1  unsigned carry out of bit WIDTH-1
- overflow  output  1  two's-complement signed overflow

Behaviour:
- Reset: all stage valid bits 0 asynchronously on rst_n low; out_valid=0, sum=0, carry=0, overflow=0, in_ready=1 while rst_n high after reset. Data registers also cleared to 0.
- Handshake: input transfer when in_valid && in_ready; output transfer when out_valid && out_ready. in_valid/a/b/cin may change freely when not accepted; out_valid/sum/carry/overflow held stable while out_valid && !out_ready.
- Stage k (0..STAGES-1) holds: valid_k, low sum bits [0 .. (k+1)*C-1], carry out of chunk k, remaining operand bits of a and b above chunk k, and MSB carry-in when chunk k contains bit WIDTH-1.
- Stage 0 computes chunk 0 from a, b, cin; stage k computes chunk k from its delayed operand bits plus stage k-1 carry register.
- Advance rule: ready_k = !valid_k || ready_{k+1}; ready_STAGES = out_ready; in_ready = ready_0 (combinational from out_ready through valid chain; no registered skid).
- Stage k loads when ready_k; valid_k <= valid_{k-1} (valid_{-1}=in_valid). Stage not loaded holds contents.
- Latency: exactly STAGES cycles from input transfer to out_valid when unstalled; throughput 1/cycle.
- Bubbles: an empty stage accepts from upstream even if downstream stalled (bubble collapse). With out_ready=0 the pipe absorbs exactly STAGES transactions, then in_ready=0.
- Simultaneous: full pipe, out_ready=1, in_valid=1 -> output retires and new input enters in same cycle, no loss.
- overflow = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, registered with final stage.
- STAGES=1: single registered adder, latency 1.
- Reset mid-operation: all in-flight transactions discarded; no partial results emitted after reset release.
- Order preserved; no reordering or duplication.

Test Plan:
- WIDTH=8, STAGES=2, out_ready=1: a=8'h00..8'h01, all 8 single-bit full-adder input combinations applied on bit 0 (a[0],b[0],cin) -> sum[0]/carry match full-adder truth table, out_valid exactly 2 cycles after each accept.
- WIDTH=8, STAGES=2: a=8'hFF, b=8'h00, cin=1 -> sum=8'h00, carry=1, overflow=0 (carry crosses chunk boundary via stage register).
- WIDTH=8: a=8'h7F, b=8'h01, cin=0 -> sum=8'h80, carry=0, overflow=1; a=8'h80, b=8'h80 -> sum=8'h00, carry=1, overflow=1.
- WIDTH=32, STAGES=4: back-to-back stream of 100 random transfers with out_ready held 1 -> one result per cycle, latency 4, all match reference model.
- Backpressure: out_ready=0, in_valid=1 continuous -> exactly 4 accepts then in_ready=0, outputs stable; release out_ready -> 4 results in order, then resumes 1/cycle; random out_ready toggling -> no loss/duplication.
- Reset: assert rst_n=0 with 3 transactions in flight mid-cycle -> out_valid=0 immediately, sum=0; after release, in_ready=1 and no stale results appear.
